dom_and_seq: RTL and testbench

//  Sequencer for the registered d-th order DOM masked AND gadget (NSHARES shares).

---
 rtl/dom_seq_pkg.sv | 24 ++
 rtl/dom_and_core.sv | 56 +++++
 rtl/dom_and_seq.sv | 128 ++++++++++++
 tb/tb_dom_and_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_seq_pkg.sv
// Shared types and index helpers for the DOM AND sequencer and gadget.
package dom_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RND,
      FEED,
      COLLECT,
      DONE,
      CLEAR
   } state_e;

   localparam int NSHARES_DEF = 6;

   function automatic int rnd_w(input int n);
      return n * (n - 1) / 2;
   endfunction

   // Pair (i>j) to bit position in the order z10,z20,z21,z30,...
   function automatic int rnd_idx(input int i, input int j);
      return i * (i - 1) / 2 + j;
   endfunction

endpackage

// File: rtl/dom_and_core.sv
// Registered DOM AND gadget: z-refreshed cross terms held in a register stage.
module dom_and_core
   import dom_seq_pkg::*;
#(
   parameter int NSHARES = NSHARES_DEF,
   parameter int RND_W   = rnd_w(NSHARES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_en,
   input  logic               clr,
   input  logic [NSHARES-1:0] a,
   input  logic [NSHARES-1:0] b,
   input  logic [RND_W-1:0]   z,
   output logic [NSHARES-1:0] c
);

   // lo_* holds a_i&b_j^z_ij (owned by share i), hi_* holds a_j&b_i^z_ij (share j)
   logic [RND_W-1:0] lo_d, lo_q;
   logic [RND_W-1:0] hi_d, hi_q;

   always_comb begin
      lo_d = '0;
      hi_d = '0;
      for (int i = 1; i < NSHARES; i++) begin
         for (int j = 0; j < i; j++) begin
            lo_d[rnd_idx(i, j)] = (a[i] & b[j]) ^ z[rnd_idx(i, j)];
            hi_d[rnd_idx(i, j)] = (a[j] & b[i]) ^ z[rnd_idx(i, j)];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_q <= '0;
         hi_q <= '0;
      end else if (clr) begin
         lo_q <= '0;
         hi_q <= '0;
      end else if (load_en) begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

   always_comb begin
      c = a & b;
      for (int i = 1; i < NSHARES; i++) begin
         for (int j = 0; j < i; j++) begin
            c[i] = c[i] ^ lo_q[rnd_idx(i, j)];
            c[j] = c[j] ^ hi_q[rnd_idx(i, j)];
         end
      end
   end

endmodule

// File: rtl/dom_and_seq.sv
// Single-op sequencer around dom_and_core; optional DOM_PRECHARGE_EN zeroes
// operand and cross-term registers in a CLEAR state between operations.
module dom_and_seq
   import dom_seq_pkg::*;
#(
   parameter int NSHARES = NSHARES_DEF,
   parameter int RND_W   = rnd_w(NSHARES),
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NSHARES-1:0] a_sh,
   input  logic [NSHARES-1:0] b_sh,
   input  logic               rnd_valid,
   output logic               rnd_ready,
   input  logic [RND_W-1:0]   rnd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NSHARES-1:0] c_sh,
   output logic [CNT_W-1:0]   ops_done
);

   state_e             state_q, state_d;
   logic [NSHARES-1:0] a_q, a_d;
   logic [NSHARES-1:0] b_q, b_d;
   logic [RND_W-1:0]   rnd_q, rnd_d;
   logic [NSHARES-1:0] c_q, c_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSHARES-1:0] core_c;
   logic               core_load;
   logic               core_clr;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      rnd_d     = rnd_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      core_load = 1'b0;
      core_clr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_sh;
               b_d     = b_sh;
               state_d = WAIT_RND;
            end
         end
         WAIT_RND: begin
            if (rnd_valid) begin
               rnd_d   = rnd_data;
               state_d = FEED;
            end
         end
         FEED: begin
            core_load = 1'b1;
            rnd_d     = '0;
            state_d   = COLLECT;
         end
         COLLECT: begin
            c_d     = core_c;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
`ifdef DOM_PRECHARGE_EN
               // zero on entry so CLEAR sits between two ops with all-zero regs
               a_d      = '0;
               b_d      = '0;
               core_clr = 1'b1;
               state_d  = CLEAR;
`else
               state_d  = IDLE;
`endif
            end
         end
         CLEAR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rnd_q   <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rnd_q   <= rnd_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

   dom_and_core #(
      .NSHARES (NSHARES),
      .RND_W   (RND_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load_en (core_load),
      .clr     (core_clr),
      .a       (a_q),
      .b       (b_q),
      .z       (rnd_q),
      .c       (core_c)
   );

   assign in_ready  = (state_q == IDLE);
   assign rnd_ready = (state_q == WAIT_RND);
   assign out_valid = (state_q == DONE);
   assign c_sh      = c_q;
   assign ops_done  = cnt_q;

endmodule

// File: tb/tb_dom_and_seq.sv
// Bench for dom_and_seq: vector table, stall sequences, random ops vs share-level model.
module tb_dom_and_seq;

   localparam int N  = 6;
   localparam int RW = 15;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic          rnd_valid;
   logic          rnd_ready;
   logic [RW-1:0] rnd_data;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  c_sh;
   logic [CW-1:0] ops_done;

   int checks   = 0;
   int failures = 0;
   int exp_ops  = 0;
   int rnd_hs   = 0;

   dom_and_seq #(
      .NSHARES (N),
      .RND_W   (RW),
      .CNT_W   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_sh      (a_sh),
      .b_sh      (b_sh),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .rnd_data  (rnd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c_sh      (c_sh),
      .ops_done  (ops_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // c_i = a_i b_i ^ sum over j!=i of (a_i b_j ^ z_{max(i,j),min(i,j)})
   function automatic logic [N-1:0] model_c(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [RW-1:0] z);
      logic [N-1:0] c;
      for (int i = 0; i < N; i++) begin
         c[i] = a[i] & b[i];
         for (int j = 0; j < N; j++) begin
            if (j != i) begin
               int hi, lo, k;
               hi = (i > j) ? i : j;
               lo = (i > j) ? j : i;
               k  = hi * (hi - 1) / 2 + lo;
               c[i] = c[i] ^ (a[i] & b[j]) ^ z[k];
            end
         end
      end
      return c;
   endfunction

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [RW-1:0] z, input int rs, input int os,
                         input logic exp_x, input string tag);
      int           lat;
      bit           bad;
      bit           rdone;
      logic [N-1:0] chold;
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      a_sh      = a;
      b_sh      = b;
      in_valid  = 1'b1;
      rnd_data  = z;
      rnd_valid = (rs == 0);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      a_sh     = N'($urandom);
      b_sh     = N'($urandom);
      lat      = 0;
      bad      = 1'b0;
      rdone    = 1'b0;
      while (!out_valid && lat < 40) begin
         if (rdone) begin
            rnd_valid = 1'($urandom_range(0, 1));
            rnd_data  = RW'($urandom);
         end else begin
            rnd_valid = (lat >= rs);
            rnd_data  = z;
         end
         if (in_ready) bad = 1'b1;
         if (!rdone && !rnd_ready) bad = 1'b1;
         if (rnd_valid && rnd_ready) begin
            rnd_hs++;
            rdone = 1'b1;
         end
         step();
         lat++;
      end
      rnd_valid = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(rs + 3));
      chk({tag, " wait handshake"}, 32'(bad), 32'd0);
      chk({tag, " c_sh"}, 32'(c_sh), 32'(model_c(a, b, z)));
      chk({tag, " xor c"}, 32'(^c_sh), 32'(exp_x));
      chold = c_sh;
      bad   = 1'b0;
      for (int s = 0; s < os; s++) begin
         in_valid  = 1'($urandom_range(0, 1));
         a_sh      = N'($urandom);
         rnd_valid = 1'($urandom_range(0, 1));
         if (rnd_valid && rnd_ready) rnd_hs++;
         step();
         if (c_sh !== chold || in_ready || !out_valid) bad = 1'b1;
      end
      if (os > 0) chk({tag, " done hold"}, 32'(bad), 32'd0);
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_ops++;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " ops_done"}, 32'(ops_done), 32'(exp_ops % (1 << CW)));
      chk({tag, " c retained"}, 32'(c_sh), 32'(chold));
`ifdef DOM_PRECHARGE_EN
      chk({tag, " clear in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " clear core"},
          32'({dut.u_core.lo_q, dut.u_core.hi_q} != '0), 32'd0);
      chk({tag, " clear ops"}, 32'({dut.a_q, dut.b_q}), 32'd0);
      step();
`endif
   endtask

   typedef struct {
      logic [N-1:0]  a;
      logic [N-1:0]  b;
      logic [RW-1:0] rnd;
      int            rs;
      int            os;
      logic          exp_x;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [N-1:0] ra, rb;
      tbl[0] = '{6'b000001, 6'b000001, 15'h5A5A, 0, 0, 1'b1};
      tbl[1] = '{6'b000011, 6'b111111, 15'h1234, 0, 1, 1'b0};
      tbl[2] = '{6'b101010, 6'b010000, 15'h0F0F, 4, 0, 1'b1};
      tbl[3] = '{6'b111111, 6'b000001, 15'h7001, 0, 5, 1'b0};
      tbl[4] = '{6'b100000, 6'b100000, 15'h7FFF, 1, 2, 1'b1};
      tbl[5] = '{6'b000000, 6'b000000, 15'h0000, 0, 0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      a_sh      = '0;
      b_sh      = '0;
      rnd_valid = 1'b0;
      rnd_data  = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset rnd_ready", 32'(rnd_ready), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset c_sh", 32'(c_sh), 32'd0);
      chk("reset ops_done", 32'(ops_done), 32'd0);
      rst = 1'b0;
      step();

      for (int v = 0; v < 6; v++) begin
         run_op(tbl[v].a, tbl[v].b, tbl[v].rnd, tbl[v].rs, tbl[v].os,
                tbl[v].exp_x, $sformatf("vec%0d", v));
      end

      rnd_hs = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = N'($urandom);
         if (^ra == 1'b0) ra[5] = ~ra[5];
         rb = N'($urandom);
         if (^rb == 1'b1) rb[0] = ~rb[0];
         run_op(ra, rb, RW'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), 1'b0, $sformatf("rand%0d", n));
      end
      chk("rnd handshakes", 32'(rnd_hs), 32'd1000);

      in_valid  = 1'b1;
      a_sh      = 6'b110101;
      b_sh      = 6'b011011;
      rnd_valid = 1'b1;
      rnd_data  = 15'h2AAA;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("collect busy", 32'({in_ready, rnd_ready, out_valid}), 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst ops_done", 32'(ops_done), 32'd0);
      chk("midrst c_sh", 32'(c_sh), 32'd0);
      rnd_valid = 1'b0;
      step();
      rst     = 1'b0;
      exp_ops = 0;
      step();
      run_op(6'b000111, 6'b001001, 15'h3C3C, 0, 1, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
